// File: rtl/clk_sw_pkg.sv
// Shared types and constants for the clock-switch controller.
// State encoding, select values, default settle time and counter sizing.
package clk_sw_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

    localparam logic SEL_CLK0 = 1'b0;
    localparam logic SEL_CLK1 = 1'b1;

    localparam int DEFAULT_SETTLE_CYCLES = 16;

    // Bits needed to hold the values 0..cycles inclusive.
    function automatic int settle_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/clk_sw_timer.sv
// Settle down-counter: loads a start value, decrements per tick, saturates at zero.
// Latency: zero reflects the count after the coming edge, so callers can leave on the edge that reaches 0.
module clk_sw_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         tick,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_d == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Select controller for a glitch-free clock mux: handles switch requests and dead-clock failover.
// Latency: done/err one cycle after acceptance; a real switch is busy SETTLE_CYCLES then done. ready low while settling or in reset.
module clk_switch_ctrl
    import clk_sw_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int AUTO_FAILOVER = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic req_sel,
    output logic ready,
    input  logic alive0,
    input  logic alive1,
    output logic sel,
    output logic busy,
    output logic done,
    output logic err,
    output logic failover
);

    localparam int CNT_W = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYCLES);

    state_e state_q;
    logic   sel_q;
    logic   done_q;
    logic   err_q;

    logic accept;
    logic alive_cur;
    logic alive_oth;
    logic target_alive;
    logic fo_cond;
    logic start_switch;
    logic tmr_zero;

    assign ready        = (state_q == ST_IDLE) && !rst;
    assign accept       = req && ready;
    assign alive_cur    = sel_q ? alive1 : alive0;
    assign alive_oth    = sel_q ? alive0 : alive1;
    assign target_alive = req_sel ? alive1 : alive0;

    // Failover waits out any done/err pulse so the three pulses never coincide.
    assign fo_cond = (AUTO_FAILOVER != 0) && (state_q == ST_IDLE) && !rst && !req
                     && !done_q && !err_q && !alive_cur && alive_oth;

    assign start_switch = (accept && (req_sel != sel_q) && target_alive) || fo_cond;

    clk_sw_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (start_switch),
        .value (SETTLE_VAL),
        .tick  (state_q == ST_SETTLE),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_CLK0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_sel == sel_q) begin
                            done_q <= 1'b1;
                        end else if (!target_alive) begin
                            err_q <= 1'b1;
                        end else begin
                            sel_q   <= req_sel;
                            state_q <= ST_SETTLE;
                        end
                    end else if (fo_cond) begin
                        sel_q   <= ~sel_q;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sel      = sel_q;
    assign busy     = (state_q == ST_SETTLE);
    assign done     = done_q;
    assign err      = err_q;
    assign failover = fo_cond;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Randomised bench for clk_switch_ctrl with an event-level reference model and pulse scoreboard.
module tb_clk_switch_ctrl;

    localparam int S = 4;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;
    localparam int K_FO   = 3;

    logic clk = 1'b0;
    logic rst, req, req_sel, alive0, alive1;
    logic ready, sel, busy, done, err, failover;

    always #5 clk = ~clk;

    clk_switch_ctrl #(
        .SETTLE_CYCLES (S),
        .AUTO_FAILOVER (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_sel  (req_sel),
        .ready    (ready),
        .alive0   (alive0),
        .alive1   (alive1),
        .sel      (sel),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .failover (failover)
    );

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;

    // Reference model: current select, last busy cycle, cycle of the next done/err pulse.
    int   m_sel = 0;
    int   m_busy_last = -1;
    int   m_pulse_at = -1;
    logic exp_sel, exp_busy, exp_ready;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        if (k == K_DONE) return "done";
        if (k == K_ERR) return "err";
        if (k == K_FO) return "failover";
        return "none";
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic switch_to(input int target, input int c);
        m_sel       = target;
        m_busy_last = c + S;
        m_pulse_at  = c + S + 1;
        exp_q.push_back('{K_DONE, c + S + 1});
    endtask

    task automatic model_step();
        int  c;
        bit  idle;
        int  a[2];
        ev_t keep[$];
        c    = cyc;
        idle = (c > m_busy_last);
        a[0] = int'(alive0);
        a[1] = int'(alive1);
        exp_sel   = logic'(m_sel);
        exp_busy  = !idle;
        exp_ready = idle && !rst;
        if (rst) begin
            foreach (exp_q[i]) if (exp_q[i].at <= c) keep.push_back(exp_q[i]);
            exp_q       = keep;
            m_sel       = 0;
            m_busy_last = -1;
            if (m_pulse_at > c) m_pulse_at = -1;
        end else if (idle) begin
            if (req) begin
                if (int'(req_sel) == m_sel) begin
                    exp_q.push_back('{K_DONE, c + 1});
                    m_pulse_at = c + 1;
                end else if (a[int'(req_sel)] == 1) begin
                    switch_to(int'(req_sel), c);
                end else begin
                    exp_q.push_back('{K_ERR, c + 1});
                    m_pulse_at = c + 1;
                end
            end else if (m_pulse_at != c && a[m_sel] == 0 && a[1 - m_sel] == 1) begin
                exp_q.push_back('{K_FO, c});
                switch_to(1 - m_sel, c);
            end
        end
    endtask

    always @(negedge clk) model_step();

    task automatic monitor_step();
        int  n;
        int  k;
        ev_t e;
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse cycle %0d: got nothing, expected %s at cycle %0d",
                     cyc, kname(e.kind), e.at);
        end
        chk("sel", int'(sel), int'(exp_sel));
        chk("busy", int'(busy), int'(exp_busy));
        chk("ready", int'(ready), int'(exp_ready));
        n = int'(done) + int'(err) + int'(failover);
        if (n > 0) begin
            chk("pulse_exclusive", n, 1);
            k = done ? K_DONE : (err ? K_ERR : K_FO);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse cycle %0d: got %s, expected none", cyc, kname(k));
            end else begin
                e = exp_q.pop_front();
                chk({"pulse_kind_", kname(e.kind)}, k, e.kind);
                chk({"pulse_cycle_", kname(e.kind)}, cyc, e.at);
            end
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (cyc >= 1) monitor_step();
    end

    task automatic drive(input bit r, input bit rq, input bit rs,
                         input bit a0, input bit a1, input int n);
        rst     = r;
        req     = rq;
        req_sel = rs;
        alive0  = a0;
        alive1  = a1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit a0, a1;
        drive(1, 0, 0, 1, 1, 3);
        // switch to clk1 with both alive
        drive(0, 1, 1, 1, 1, 1);
        drive(0, 0, 0, 1, 1, S + 2);
        drive(0, 1, 0, 1, 1, 1);
        drive(0, 0, 0, 1, 1, S + 2);
        // no-op request to the current clock
        drive(0, 1, 0, 1, 1, 1);
        drive(0, 0, 0, 1, 1, 3);
        // request toward a dead clock
        drive(0, 1, 1, 1, 0, 1);
        drive(0, 0, 0, 1, 0, 2);
        // clk0 dies while clk1 alive
        drive(0, 0, 0, 0, 1, S + 4);
        drive(0, 0, 0, 1, 1, 1);
        // reset in the second settle cycle
        drive(0, 1, 0, 1, 1, 1);
        drive(0, 0, 0, 1, 1, S + 2);
        drive(0, 1, 1, 1, 1, 1);
        drive(0, 0, 0, 1, 1, 1);
        drive(1, 0, 0, 1, 1, 1);
        drive(0, 0, 0, 1, 1, 4);
        // both clocks dead
        drive(0, 0, 0, 0, 0, 20);
        a0 = 1'b1;
        a1 = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) a0 = ~a0;
            if ($urandom_range(0, 7) == 0) a1 = ~a1;
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                  bit'($urandom_range(0, 1)), a0, a1, 1);
        end
        drive(0, 0, 0, 1, 1, S + 4);
        @(negedge clk);
        #2;
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
